// File: rtl/qea_host_ctrl.sv
// Host-side sequencer for the QEA core: loads gate context, seeds the state RAM
// with |0...0>, launches a run, watches for completion/timeout and streams the final state out.
module qea_host_ctrl #(
  parameter int PE_NUM_WIDTH            = 2,
  parameter int PE_NUM                  = 4,
  parameter int STATE_DATA_WIDTH        = 64,
  parameter int STATE_ADDR_WIDTH        = 16,
  parameter int GATE_CONTEXT_DATA_WIDTH = 64,
  parameter int GATE_CONTEXT_ADDR_WIDTH = 16,
  parameter int MAX_QBIT_WIDTH          = 6,
  parameter int NUM_FRAC_BIT            = 30,
  parameter int RD_LATENCY              = 1,
  parameter int TIMEOUT_WIDTH           = 32
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 i_cmd_start,
  input  logic [MAX_QBIT_WIDTH-1:0]            i_qbit_num,
  input  logic [GATE_CONTEXT_ADDR_WIDTH-1:0]   i_ins_num,
  input  logic [TIMEOUT_WIDTH-1:0]             i_timeout,
  input  logic                                 i_ctx_valid,
  output logic                                 o_ctx_ready,
  input  logic [GATE_CONTEXT_DATA_WIDTH-1:0]   i_ctx_data,
  output logic                                 o_rd_valid,
  input  logic                                 i_rd_ready,
  output logic [PE_NUM*STATE_DATA_WIDTH-1:0]   o_rd_data,
  output logic [STATE_ADDR_WIDTH-1:0]          o_rd_addr,
  output logic                                 o_busy,
  output logic                                 o_done,
  output logic                                 o_err,
  output logic                                 o_qea_start,
  output logic [MAX_QBIT_WIDTH-1:0]            o_qea_qbit_num,
  output logic                                 o_qea_ctx_en,
  output logic                                 o_qea_ctx_wea,
  output logic [GATE_CONTEXT_ADDR_WIDTH-1:0]   o_qea_ctx_addr,
  output logic [GATE_CONTEXT_DATA_WIDTH-1:0]   o_qea_ctx_data,
  output logic                                 o_qea_state_ena,
  output logic                                 o_qea_state_wea,
  output logic [STATE_ADDR_WIDTH-1:0]          o_qea_state_addra,
  output logic [PE_NUM*STATE_DATA_WIDTH-1:0]   o_qea_state_dina,
  input  logic                                 i_qea_complete,
  input  logic [PE_NUM*STATE_DATA_WIDTH-1:0]   i_qea_state_dout
);

  localparam int RAM_DW    = PE_NUM * STATE_DATA_WIDTH;
  localparam int HALF_W    = STATE_DATA_WIDTH / 2;
  localparam int LAT_W     = $clog2(RD_LATENCY + 1);
  localparam int CW        = GATE_CONTEXT_ADDR_WIDTH + 1;
  localparam int SW        = STATE_ADDR_WIDTH + 1;
  // Amplitude 1.0 in fixed point, placed in the real half of the top PE slot.
  localparam logic [HALF_W-1:0] ONE_FX    = {{(HALF_W-1){1'b0}}, 1'b1} << NUM_FRAC_BIT;
  localparam logic [RAM_DW-1:0] INIT_WORD = {ONE_FX, {(RAM_DW-HALF_W){1'b0}}};
  localparam logic [CW-1:0]     CTX_ONE   = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [SW-1:0]     ST_ONE    = {{(SW-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_CTX, S_INIT_STATE, S_START, S_RUN, S_READOUT, S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [MAX_QBIT_WIDTH-1:0]          qbit_q;
  logic [GATE_CONTEXT_ADDR_WIDTH-1:0] ins_q;
  logic [TIMEOUT_WIDTH-1:0]           timeout_q, run_cnt;
  logic [CW-1:0]                      ctx_cnt;
  logic [SW-1:0]                      st_cnt, last_addr;
  logic [MAX_QBIT_WIDTH-1:0]          addr_bits;
  logic [LAT_W-1:0]                   lat_cnt;
  logic                               rd_issue, err_done;
  logic                               accept, qbit_ok, ctx_hs, ctx_last, st_last, rd_hs, timed_out;

  assign accept    = (state == S_IDLE) && i_cmd_start;
  assign qbit_ok   = (int'(i_qbit_num) > PE_NUM_WIDTH) &&
                     (int'(i_qbit_num) <= PE_NUM_WIDTH + STATE_ADDR_WIDTH);
  assign addr_bits = qbit_q - MAX_QBIT_WIDTH'(PE_NUM_WIDTH);
  assign last_addr = (ST_ONE << addr_bits) - ST_ONE;
  assign st_last   = (st_cnt == last_addr);
  assign ctx_hs    = i_ctx_valid && o_ctx_ready;
  assign ctx_last  = ((ctx_cnt + CTX_ONE) == {1'b0, ins_q});
  assign rd_hs     = o_rd_valid && i_rd_ready;
  assign timed_out = (timeout_q != '0) && (run_cnt == timeout_q - TIMEOUT_WIDTH'(1));
  assign o_qea_qbit_num = qbit_q;

  // NOTE: every signal driven here is given a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_nxt         = state;
    o_busy            = (state != S_IDLE);
    o_done            = (state == S_DONE) || err_done;
    o_qea_start       = (state == S_START);
    o_ctx_ready       = 1'b0;
    o_qea_ctx_en      = 1'b0;
    o_qea_ctx_wea     = 1'b0;
    o_qea_ctx_addr    = '0;
    o_qea_ctx_data    = '0;
    o_qea_state_ena   = 1'b0;
    o_qea_state_wea   = 1'b0;
    o_qea_state_addra = '0;
    o_qea_state_dina  = '0;
    unique case (state)
      S_IDLE: if (accept && qbit_ok) state_nxt = S_LOAD_CTX;
      S_LOAD_CTX: begin
        o_ctx_ready = (ctx_cnt < {1'b0, ins_q});
        if (ctx_hs) begin
          o_qea_ctx_en   = 1'b1;
          o_qea_ctx_wea  = 1'b1;
          o_qea_ctx_addr = ctx_cnt[GATE_CONTEXT_ADDR_WIDTH-1:0];
          o_qea_ctx_data = i_ctx_data;
        end
        if (ins_q == '0 || (ctx_hs && ctx_last)) state_nxt = S_INIT_STATE;
      end
      S_INIT_STATE: begin
        o_qea_state_ena   = 1'b1;
        o_qea_state_wea   = 1'b1;
        o_qea_state_addra = st_cnt[STATE_ADDR_WIDTH-1:0];
        o_qea_state_dina  = (st_cnt == '0) ? INIT_WORD : '0;
        if (st_last) state_nxt = S_START;
      end
      S_START: state_nxt = S_RUN;
      S_RUN: begin
        // The core's complete flag may still be stale in the first cycle after start.
        if (i_qea_complete && run_cnt != '0) state_nxt = S_READOUT;
        else if (timed_out)                  state_nxt = S_DONE;
      end
      S_READOUT: begin
        if (rd_issue) begin
          o_qea_state_ena   = 1'b1;
          o_qea_state_addra = st_cnt[STATE_ADDR_WIDTH-1:0];
        end
        if (rd_hs && st_last) state_nxt = S_DONE;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // NOTE: all state-holding registers use non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      qbit_q     <= '0;
      ins_q      <= '0;
      timeout_q  <= '0;
      run_cnt    <= '0;
      ctx_cnt    <= '0;
      st_cnt     <= '0;
      lat_cnt    <= '0;
      rd_issue   <= 1'b0;
      err_done   <= 1'b0;
      o_err      <= 1'b0;
      o_rd_valid <= 1'b0;
      o_rd_data  <= '0;
      o_rd_addr  <= '0;
    end else begin
      state    <= state_nxt;
      err_done <= accept && !qbit_ok;
      case (state)
        S_IDLE: if (accept) begin
          o_err   <= !qbit_ok;
          ctx_cnt <= '0;
          st_cnt  <= '0;
          if (qbit_ok) begin
            qbit_q    <= i_qbit_num;
            ins_q     <= i_ins_num;
            timeout_q <= i_timeout;
          end
        end
        S_LOAD_CTX:   if (ctx_hs) ctx_cnt <= ctx_cnt + CTX_ONE;
        S_INIT_STATE: st_cnt <= st_last ? '0 : st_cnt + ST_ONE;
        S_START:      run_cnt <= '0;
        S_RUN: begin
          if (run_cnt != '1) run_cnt <= run_cnt + TIMEOUT_WIDTH'(1);
          if (state_nxt == S_READOUT) rd_issue <= 1'b1;
          if (state_nxt == S_DONE)    o_err    <= 1'b1;
        end
        S_READOUT: begin
          if (rd_issue) begin
            rd_issue <= 1'b0;
            lat_cnt  <= LAT_W'(RD_LATENCY);
          end else if (lat_cnt != '0) begin
            lat_cnt <= lat_cnt - LAT_W'(1);
            if (lat_cnt == LAT_W'(1)) begin
              o_rd_valid <= 1'b1;
              o_rd_data  <= i_qea_state_dout;
              o_rd_addr  <= st_cnt[STATE_ADDR_WIDTH-1:0];
            end
          end else if (rd_hs) begin
            o_rd_valid <= 1'b0;
            if (!st_last) begin
              st_cnt   <= st_cnt + ST_ONE;
              rd_issue <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_qea_host_ctrl.sv
// Directed bench for qea_host_ctrl: context load, state init, run/timeout,
// stalled readout against a state-RAM model, bad qubit counts and mid-run reset.
module tb_qea_host_ctrl;
  localparam int DW  = 256;
  localparam logic [DW-1:0] INIT_W = {64'h40000000_00000000, 192'h0};

  logic           clk = 1'b0, rst_n = 1'b0;
  logic           i_cmd_start = 1'b0;
  logic [5:0]     i_qbit_num = '0;
  logic [15:0]    i_ins_num = '0;
  logic [31:0]    i_timeout = '0;
  logic           i_ctx_valid = 1'b0, o_ctx_ready;
  logic [63:0]    i_ctx_data = '0;
  logic           o_rd_valid, i_rd_ready = 1'b0;
  logic [DW-1:0]  o_rd_data;
  logic [15:0]    o_rd_addr;
  logic           o_busy, o_done, o_err, o_qea_start;
  logic [5:0]     o_qea_qbit_num;
  logic           o_qea_ctx_en, o_qea_ctx_wea;
  logic [15:0]    o_qea_ctx_addr;
  logic [63:0]    o_qea_ctx_data;
  logic           o_qea_state_ena, o_qea_state_wea;
  logic [15:0]    o_qea_state_addra;
  logic [DW-1:0]  o_qea_state_dina;
  logic           i_qea_complete = 1'b0;
  logic [DW-1:0]  i_qea_state_dout = '0;

  qea_host_ctrl dut (
    .clk(clk), .rst_n(rst_n), .i_cmd_start(i_cmd_start), .i_qbit_num(i_qbit_num),
    .i_ins_num(i_ins_num), .i_timeout(i_timeout), .i_ctx_valid(i_ctx_valid),
    .o_ctx_ready(o_ctx_ready), .i_ctx_data(i_ctx_data), .o_rd_valid(o_rd_valid),
    .i_rd_ready(i_rd_ready), .o_rd_data(o_rd_data), .o_rd_addr(o_rd_addr),
    .o_busy(o_busy), .o_done(o_done), .o_err(o_err), .o_qea_start(o_qea_start),
    .o_qea_qbit_num(o_qea_qbit_num), .o_qea_ctx_en(o_qea_ctx_en), .o_qea_ctx_wea(o_qea_ctx_wea),
    .o_qea_ctx_addr(o_qea_ctx_addr), .o_qea_ctx_data(o_qea_ctx_data),
    .o_qea_state_ena(o_qea_state_ena), .o_qea_state_wea(o_qea_state_wea),
    .o_qea_state_addra(o_qea_state_addra), .o_qea_state_dina(o_qea_state_dina),
    .i_qea_complete(i_qea_complete), .i_qea_state_dout(i_qea_state_dout)
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_pass = 0;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [63:0] ctx_word(input int k);
    return {16'hC0DE, 16'(k), ~32'(k)};
  endfunction

  function automatic logic [DW-1:0] dout_model(input logic [15:0] a);
    logic [DW-1:0] w;
    for (int p = 0; p < 4; p++) w[p*64 +: 64] = {8'(p), 8'h3C, a, ~a, 16'(a * 3)};
    return w;
  endfunction

  // State RAM model, one cycle read latency.
  always @(posedge clk)
    if (o_qea_state_ena && !o_qea_state_wea) i_qea_state_dout <= dout_model(o_qea_state_addra);

  // Monitor state, sampled on the falling edge.
  int cyc = 0, ctx_wr, ctx_bad, ctx_first, ctx_last, st_wr, st_bad, rd_iss, start_cnt, start_cyc;
  int done_cnt, done_cyc, beats, rd_bad, qbit_bad, act, ctx_sent, gap_phase;
  logic done_err, rd_hold, ctx_hs;
  logic [15:0]   hold_addr;
  logic [DW-1:0] hold_data;
  logic [5:0]    exp_qbit;
  bit   ctx_on = 0, ctx_gap = 0;
  int   rd_mode = 0;

  always @(negedge clk) begin
    cyc++;
    if (o_qea_ctx_en) begin
      if (ctx_wr == 0) ctx_first = cyc;
      ctx_last = cyc;
      if (!o_qea_ctx_wea || o_qea_ctx_addr != 16'(ctx_wr) || o_qea_ctx_data != ctx_word(ctx_wr)) ctx_bad++;
      ctx_wr++;
    end
    if (o_qea_state_ena && o_qea_state_wea) begin
      if (o_qea_state_addra != 16'(st_wr) || o_qea_state_dina != ((st_wr == 0) ? INIT_W : '0)) st_bad++;
      st_wr++;
    end
    if (o_qea_state_ena && !o_qea_state_wea) rd_iss++;
    if (o_qea_start) begin start_cnt++; start_cyc = cyc; end
    if (o_done) begin done_cnt++; done_cyc = cyc; done_err = o_err; end
    if (o_busy && o_qea_qbit_num != exp_qbit) qbit_bad++;
    if (o_qea_ctx_en || o_qea_state_ena || o_qea_start) act++;
    if (rd_hold && (!o_rd_valid || o_rd_addr != hold_addr || o_rd_data != hold_data)) rd_bad++;
    if (o_rd_valid && i_rd_ready) begin
      if (o_rd_addr != 16'(beats) || o_rd_data != dout_model(16'(beats))) rd_bad++;
      beats++;
    end
    rd_hold   = o_rd_valid && !i_rd_ready;
    hold_addr = o_rd_addr;
    hold_data = o_rd_data;
    ctx_hs    = i_ctx_valid && o_ctx_ready;
  end

  // Context source and readout sink, driven just after the rising edge.
  always @(posedge clk) begin
    #1;
    if (ctx_hs) ctx_sent++;
    gap_phase   = (gap_phase + 1) % 3;
    i_ctx_valid = ctx_on && !(ctx_gap && gap_phase == 2);
    i_ctx_data  = ctx_word(ctx_sent);
    i_rd_ready  = (rd_mode == 1) ? 1'b1 : (rd_mode == 2) ? ~i_rd_ready : 1'b0;
  end

  task automatic clear_mon();
    ctx_wr = 0; ctx_bad = 0; ctx_first = 0; ctx_last = 0; st_wr = 0; st_bad = 0; rd_iss = 0;
    start_cnt = 0; start_cyc = 0; done_cnt = 0; done_cyc = 0; done_err = 1'b0; beats = 0;
    rd_bad = 0; qbit_bad = 0; act = 0; ctx_sent = 0; gap_phase = 0; rd_hold = 1'b0; ctx_hs = 1'b0;
  endtask

  task automatic issue(input int qbit, input int ins, input int tmo);
    @(posedge clk); #2;
    i_qbit_num = 6'(qbit); i_ins_num = 16'(ins); i_timeout = 32'(tmo); i_cmd_start = 1'b1;
    @(posedge clk); #2;
    i_cmd_start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int limit);
    for (int i = 0; i < limit && done_cnt == 0; i++) @(negedge clk);
    check({tag, "_finished"}, 256'(done_cnt != 0), 256'(1));
  endtask

  // cdelay < 0: complete is never raised.
  task automatic run_seq(input string tag, input int qbit, input int ins, input int tmo,
                         input bit gap, input int rmode, input int cdelay, input int limit);
    @(posedge clk); #2;
    clear_mon();
    exp_qbit = 6'(qbit); ctx_on = 1; ctx_gap = gap; rd_mode = rmode;
    issue(qbit, ins, tmo);
    if (cdelay >= 0) begin
      for (int i = 0; i < limit && start_cnt == 0; i++) @(negedge clk);
      repeat (cdelay) @(posedge clk);
      #2 i_qea_complete = 1'b1;
    end
    wait_done(tag, limit);
    @(posedge clk); #2;
    i_qea_complete = 1'b0; ctx_on = 0; rd_mode = 0;
    repeat (2) @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ctl"}, 256'({o_busy, o_done, o_err, o_ctx_ready, o_rd_valid, o_qea_start, o_qea_ctx_en,
                               o_qea_ctx_wea, o_qea_state_ena, o_qea_state_wea, o_qea_qbit_num,
                               o_rd_addr, o_qea_ctx_addr, o_qea_state_addra}), 256'(0));
    check({tag, "_data"}, o_rd_data | o_qea_state_dina | 256'(o_qea_ctx_data), 256'(0));
  endtask

  initial begin
    clear_mon();
    exp_qbit = '0;
    // Reset with a start request held: nothing may be accepted.
    i_qbit_num = 6'd5; i_ins_num = 16'd1; i_cmd_start = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk); #2;
    rst_n = 1'b1; i_cmd_start = 1'b0;
    repeat (3) @(negedge clk);
    check("start_in_reset_ignored", 256'(o_busy | o_done), 256'(0));

    // Out-of-range qubit counts.
    run_seq("qbit2", 2, 4, 0, 0, 1, -1, 20);
    check("qbit2_done", 256'(done_cnt), 256'(1));
    check("qbit2_err", 256'(done_err), 256'(1));
    check("qbit2_activity", 256'(act), 256'(0));
    run_seq("qbit19", 19, 4, 0, 0, 1, -1, 20);
    check("qbit19_done", 256'(done_cnt), 256'(1));
    check("qbit19_err", 256'(done_err), 256'(1));
    check("qbit19_activity", 256'(act), 256'(0));

    // Full run: 427 context words, 2048 state words, stalled readout.
    run_seq("main", 13, 427, 0, 0, 2, 50, 20000);
    check("main_ctx_writes", 256'(ctx_wr), 256'(427));
    check("main_ctx_content", 256'(ctx_bad), 256'(0));
    check("main_ctx_span", 256'(ctx_last - ctx_first + 1), 256'(427));
    check("main_state_writes", 256'(st_wr), 256'(2048));
    check("main_state_content", 256'(st_bad), 256'(0));
    check("main_start_pulses", 256'(start_cnt), 256'(1));
    check("main_read_issues", 256'(rd_iss), 256'(2048));
    check("main_beats", 256'(beats), 256'(2048));
    check("main_readout_data", 256'(rd_bad), 256'(0));
    check("main_qbit_stable", 256'(qbit_bad), 256'(0));
    check("main_done", 256'(done_cnt), 256'(1));
    check("main_err", 256'(done_err), 256'(0));

    // Timeout with complete never raised: 100 RUN cycles, then DONE.
    run_seq("tmo", 3, 2, 100, 0, 1, -1, 400);
    check("tmo_done", 256'(done_cnt), 256'(1));
    check("tmo_err", 256'(done_err), 256'(1));
    check("tmo_latency", 256'(done_cyc - start_cyc), 256'(101));
    check("tmo_no_readout", 256'(beats + rd_iss), 256'(0));
    check("tmo_err_sticky", 256'(o_err), 256'(1));

    // Gappy context stream, then an empty context.
    run_seq("gap", 4, 10, 0, 1, 1, 3, 300);
    check("gap_ctx_writes", 256'(ctx_wr), 256'(10));
    check("gap_ctx_content", 256'(ctx_bad), 256'(0));
    check("gap_state_writes", 256'(st_wr), 256'(4));
    check("gap_beats", 256'(beats), 256'(4));
    check("gap_readout_data", 256'(rd_bad), 256'(0));
    run_seq("ins0", 3, 0, 0, 0, 1, 3, 300);
    check("ins0_ctx_writes", 256'(ctx_wr), 256'(0));
    check("ins0_state_writes", 256'(st_wr), 256'(2));
    check("ins0_state_content", 256'(st_bad), 256'(0));
    check("ins0_beats", 256'(beats), 256'(2));
    check("ins0_err", 256'(done_err), 256'(0));

    // Reset in the middle of INIT_STATE.
    @(posedge clk); #2;
    clear_mon();
    exp_qbit = 6'd13;
    issue(13, 0, 0);
    for (int i = 0; i < 200 && st_wr < 20; i++) @(negedge clk);
    check("init_reached", 256'(st_wr >= 20), 256'(1));
    @(posedge clk); #2 rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_all_zero("rst_init");
    repeat (2) @(negedge clk);
    check("rst_init_no_done", 256'(done_cnt), 256'(0));
    @(posedge clk); #2 rst_n = 1'b1;

    // Reset while the readout is stalled.
    @(posedge clk); #2;
    clear_mon();
    exp_qbit = 6'd3; ctx_on = 1; rd_mode = 0;
    issue(3, 1, 0);
    for (int i = 0; i < 50 && start_cnt == 0; i++) @(negedge clk);
    repeat (2) @(posedge clk);
    #2 i_qea_complete = 1'b1;
    for (int i = 0; i < 50 && !o_rd_valid; i++) @(negedge clk);
    check("stall_valid", 256'(o_rd_valid), 256'(1));
    repeat (3) @(negedge clk);
    check("stall_hold", 256'(rd_bad), 256'(0));
    @(posedge clk); #2 rst_n = 1'b0; i_qea_complete = 1'b0; ctx_on = 0;
    @(posedge clk);
    @(negedge clk);
    check_all_zero("rst_readout");
    check("rst_readout_no_done", 256'(done_cnt), 256'(0));
    @(posedge clk); #2 rst_n = 1'b1;

    // Fresh run after reset.
    run_seq("rerun", 5, 3, 0, 0, 2, 4, 400);
    check("rerun_ctx_writes", 256'(ctx_wr), 256'(3));
    check("rerun_state_writes", 256'(st_wr), 256'(8));
    check("rerun_state_content", 256'(st_bad), 256'(0));
    check("rerun_beats", 256'(beats), 256'(8));
    check("rerun_readout_data", 256'(rd_bad), 256'(0));
    check("rerun_done", 256'(done_cnt), 256'(1));
    check("rerun_err", 256'(done_err), 256'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/qea_host_ctrl.md
QEA_HOST_CTRL -- requirements
Module: qea_host_ctrl

Interface
REQ-001 Parameters, default, meaning: PE_NUM_WIDTH 2 log2 PE count; PE_NUM 4 PEs; STATE_DATA_WIDTH 64 complex amplitude {re,im}; STATE_ADDR_WIDTH 16; GATE_CONTEXT_DATA_WIDTH 64; GATE_CONTEXT_ADDR_WIDTH 16; MAX_QBIT_WIDTH 6; NUM_FRAC_BIT 30; RD_LATENCY 1 state RAM read latency in cycles; TIMEOUT_WIDTH 32.
REQ-002 clk  in  1  single clock; all logic rising-edge.
REQ-003 rst_n  in  1  reset, synchronous, active-low.
REQ-004 i_cmd_start  in  1  one-cycle run request; ignored unless IDLE.
REQ-005 i_qbit_num  in  MAX_QBIT_WIDTH  qubit count, sampled on accepted i_cmd_start.
REQ-006 i_ins_num  in  GATE_CONTEXT_ADDR_WIDTH  context word count, sampled on accepted i_cmd_start.
REQ-007 i_timeout  in  TIMEOUT_WIDTH  max RUN cycles; 0 disables; sampled on accepted i_cmd_start.
REQ-008 i_ctx_valid / o_ctx_ready / i_ctx_data  in / out / in  1 / 1 / GATE_CONTEXT_DATA_WIDTH  context word stream.
REQ-009 o_rd_valid / i_rd_ready / o_rd_data / o_rd_addr  out / in / out / out  1 / 1 / PE_NUM*STATE_DATA_WIDTH / STATE_ADDR_WIDTH  final state readout stream.
REQ-010 o_busy, o_done, o_err  out  1 each  not IDLE; one-cycle completion pulse; sticky error, cleared on next accepted start.
REQ-011 o_qea_start, o_qea_qbit_num (MAX_QBIT_WIDTH), o_qea_ctx_en, o_qea_ctx_wea, o_qea_ctx_addr (GATE_CONTEXT_ADDR_WIDTH), o_qea_ctx_data (GATE_CONTEXT_DATA_WIDTH)  out  drive QEA control/context ports.
REQ-012 o_qea_state_ena, o_qea_state_wea (1), o_qea_state_addra (STATE_ADDR_WIDTH), o_qea_state_dina (PE_NUM*STATE_DATA_WIDTH)  out  drive QEA state RAM port A.
REQ-013 i_qea_complete (1), i_qea_state_dout (PE_NUM*STATE_DATA_WIDTH)  in  QEA status and state RAM read data.

Function
REQ-014 FSM states: IDLE, LOAD_CTX, INIT_STATE, START, RUN, READOUT, DONE.
REQ-015 IDLE: accepted i_cmd_start with PE_NUM_WIDTH < i_qbit_num <= PE_NUM_WIDTH+STATE_ADDR_WIDTH -> LOAD_CTX; otherwise o_err=1, o_done pulses next cycle, stay IDLE.
REQ-016 LOAD_CTX: o_ctx_ready=1; each i_ctx_valid&&o_ctx_ready writes one word: ctx_en=wea=1, addr=k (k from 0), data=i_ctx_data registered same cycle; after word i_ins_num-1 -> INIT_STATE; i_ins_num=0 skips directly to INIT_STATE.
REQ-017 INIT_STATE: writes N=2**(qbit_num-PE_NUM_WIDTH) words, one per cycle, addr 0..N-1, ena=wea=1; addr 0 data = (1<<NUM_FRAC_BIT) in real half of top slot bits [PE_NUM*64-1 -: 64] (value 0x40000000_00000000 for defaults), all other bits/words zero; then START.
REQ-018 START: o_qea_start=1 exactly one cycle, o_qea_qbit_num held stable for entire run; -> RUN.
REQ-019 RUN: i_qea_complete ignored in first cycle after START; i_qea_complete=1 -> READOUT; cycle counter reaches nonzero timeout -> o_err=1, DONE (no readout).
REQ-020 READOUT: per address a=0..N-1: ena=1, wea=0, addra=a for one cycle; data captured RD_LATENCY cycles later; o_rd_valid=1, o_rd_addr=a held until i_rd_ready; next read issued the cycle after handshake; after a=N-1 handshake -> DONE.
REQ-021 o_rd_data/o_rd_addr stable while o_rd_valid && !i_rd_ready.
REQ-022 DONE: o_done=1 one cycle -> IDLE; i_cmd_start in DONE ignored.
REQ-023 Ctx/state enables zero in every state except their write/read cycles; no state RAM write outside INIT_STATE.
REQ-024 Counters wrap never: address counters sized STATE_ADDR_WIDTH+1 / GATE_CONTEXT_ADDR_WIDTH+1.

Reset
REQ-025 rst_n=0 at clk edge: state IDLE; all outputs 0, counters 0, o_err 0; applies mid-operation, aborts any phase without a done pulse.
REQ-026 i_cmd_start asserted in the reset cycle is not accepted.

Verification
REQ-027 qbit_num=13, ins_num=427, ctx_valid always 1 -> 427 ctx writes addr 0..426 in 427 consecutive cycles, then 2048 state writes, addr 0 = 0x40000000_00000000 in top slot.
REQ-028 complete asserted 50 cycles after start pulse, i_rd_ready toggling 1/0 -> 2048 readout beats addr 0..2047 in order, data equals QEA dout model, one o_done pulse.
REQ-029 qbit_num=2 and qbit_num=19 -> o_err=1, o_done pulse, zero QEA port activity.
REQ-030 timeout=100, complete never asserted -> o_err=1 at RUN cycle 100, o_done pulse, no readout beats.
REQ-031 ctx_valid gaps (1 of every 3 cycles) -> write count exactly ins_num, addresses contiguous; ins_num=0 -> no ctx writes.
REQ-032 rst_n=0 during INIT_STATE and during READOUT stall -> all outputs 0 next cycle; new start after reset runs full sequence correctly.
